recibidor_pcie: RTL and testbench
=================================

# recibidor_pcie

Serial receive path of the PCIe-style lane interface. It takes a 1-bit-per-clock 8b/10b serial stream and aligns to K28.5 commas. It decodes each 10-bit symbol to a byte plus K flag and presents the bytes as 8-, 16- or 32-bit words, selected by `dataS`. It is the counterpart of the lane transmitter/serializer.

## Interface
Parameters: none. Code-group width is fixed at 10 and byte width at 8.

Reset is synchronous and active-high; there is one clock, `clk`.

- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous active-high reset
- `enb`  in  1  enable; when low, all state holds
- `serialIn`  in  1  serial bit; one bit is sampled per enabled edge; bit `a` of each code-group arrives first
- `dataS`  in  2  width select: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = same as 00
- `dataOut8`  out  8  last decoded byte (8-bit mode)
- `dataOut16`  out  16  last two bytes (16-bit mode)
- `dataOut32`  out  32  last four bytes (32-bit mode)
- `k_out`  out  1  high when the last decoded symbol was a K (control) code

## Operation
- Shift register `sr[9:0]`. Each enabled edge computes `nxt = {sr[8:0], serialIn}` and loads it into `sr`. `nxt[9]` is bit `a`; the code-group reads `abcdei fghj`, MSB first.
- Comma detect: `nxt` = 0011111010 (K28.5 RD−) or 1100000101 (K28.5 RD+). Detection is active at every bit position, aligned or not.
  - On detect: set `aligned`=1, clear bit counter `cnt` (0..9), clear byte counter `bcnt`, and decode `nxt`.
- When aligned with no comma: if `cnt`==9, decode `nxt` and set `cnt`=0; otherwise increment `cnt`.
- When not aligned: no decoding; outputs hold.
- Decode uses the standard 5b/6b and 3b/4b tables and accepts both running disparities. Running disparity is not checked.
  - Byte = HGFEDCBA.
  - K28.x and K23.7/K27.7/K29.7/K30.7 set `k_out`=1.
  - Invalid code: byte 0x00, `k_out`=0.
- Width assembly on each decoded byte `d`. Non-selected outputs are held at 0.
  - 8-bit: `dataOut8` <= `d`.
  - 16-bit: the first byte is staged into bits [7:0] of a staging register; the second byte completes it. `dataOut16` <= {`d`, stage[7:0]}, updated only every 2nd byte.
  - 32-bit: same scheme with 4 bytes, first byte in [7:0]. `dataOut32` updates only every 4th byte.
  - `bcnt` wraps 0..(N−1). A comma always restarts the word, so the comma byte 0xBC is byte 0.
- A change of `dataS` clears `bcnt` and all three outputs on the next enabled edge.
- `k_out` always reflects the most recent decoded symbol, in every mode.

## Timing
- Reset (`rst`=1 at an edge, regardless of `enb`): `sr`=0, `aligned`=0, `cnt`=0, `bcnt`=0, all `dataOut*`=0, `k_out`=0.
- Reset mid-symbol discards the partial symbol; realignment requires a new comma.
- Latency: outputs update on the same edge that samples bit `j` of the symbol, i.e. zero extra cycles after the 10th bit.
- `enb`=0: nothing shifts or counts; bits presented at those edges are ignored.
- A comma appearing mid-symbol while aligned realigns immediately. Any partial word in progress is discarded.

## Structure
- Shared package `pcie_8b10b_pkg`:
  - K28.5 RD− / RD+ constants
  - `DATAS_8` / `DATAS_16` / `DATAS_32` encodings
  - K-code list
- Sub-module `decod_8b10b`: purely combinational, 10-bit code in, 8-bit byte + `k` + `invalid` out.
- Top level holds the shift register, aligner, counters and width assembly.

## Test plan
- Reset then random bits containing no comma pattern -> `aligned` stays 0; all outputs remain 0.
- `dataS`=00, stream K28.5 RD− (0011111010) then D21.5 (1010101010):
  - after the comma: `dataOut8`=0xBC, `k_out`=1
  - 10 bits later: `dataOut8`=0xB5, `k_out`=0
- `dataS`=01, stream K28.5, D10.2 (0101010101) -> `dataOut16`=0x4ABC, `k_out`=0. `dataOut8` and `dataOut32` stay 0.
- `dataS`=10, stream K28.5, D21.5, D10.2, D0.0 RD− (1001110100) -> `dataOut32`=0x004AB5BC after the 40th bit. No update before that.
- `enb` low for 7 cycles in the middle of a symbol -> result is identical to the uninterrupted stream, delayed by 7 cycles.
- `rst` pulsed mid-symbol, then D21.5 without a comma -> outputs stay 0; after a new K28.5, `dataOut8`=0xBC.

Source files
------------

// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b constants for the lane receive/transmit pair.
// Latency: n/a (constants and a combinational helper).
// Backpressure: n/a.
//   Contents: K28.5 comma code-groups, dataS width encodings, K-code byte list.
package pcie_8b10b_pkg;

  // Comma code-groups, abcdei_fghj with bit a in [9].
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Output width select encodings; 2'b11 behaves as DATAS_8.
  localparam logic [1:0] DATAS_8  = 2'b00;
  localparam logic [1:0] DATAS_16 = 2'b01;
  localparam logic [1:0] DATAS_32 = 2'b10;

  // Every byte value that has a legal K (control) encoding.
  localparam int NUM_K_CODES = 12;
  localparam logic [7:0] K_CODES [NUM_K_CODES] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  function automatic logic is_k_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_K_CODES; i++) begin
      if (K_CODES[i] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/decod_8b10b.sv
// 8b/10b code-group decoder, both running disparities accepted, disparity unchecked.
// Latency: purely combinational.
// Backpressure: none.
//   Ports: code[9:0] (abcdei_fghj, a in [9]) in; data[7:0] (HGFEDCBA), k, invalid out.
//   data/k are only meaningful while invalid is low.
module decod_8b10b
  import pcie_8b10b_pkg::*;
(
  input  logic [9:0] code,
  output logic [7:0] data,
  output logic       k,
  output logic       invalid
);

  logic [4:0] x5;
  logic [2:0] y3;
  logic       v6;
  logic       v4;
  logic       k28;
  logic       a7;
  logic [3:0] four_k;

  always_comb begin
    x5  = '0;
    v6  = 1'b1;
    k28 = 1'b0;
    case (code[9:4])
      6'b100111, 6'b011000: x5 = 5'd0;
      6'b011101, 6'b100010: x5 = 5'd1;
      6'b101101, 6'b010010: x5 = 5'd2;
      6'b110001:            x5 = 5'd3;
      6'b110101, 6'b001010: x5 = 5'd4;
      6'b101001:            x5 = 5'd5;
      6'b011001:            x5 = 5'd6;
      6'b111000, 6'b000111: x5 = 5'd7;
      6'b111001, 6'b000110: x5 = 5'd8;
      6'b100101:            x5 = 5'd9;
      6'b010101:            x5 = 5'd10;
      6'b110100:            x5 = 5'd11;
      6'b001101:            x5 = 5'd12;
      6'b101100:            x5 = 5'd13;
      6'b011100:            x5 = 5'd14;
      6'b010111, 6'b101000: x5 = 5'd15;
      6'b011011, 6'b100100: x5 = 5'd16;
      6'b100011:            x5 = 5'd17;
      6'b010011:            x5 = 5'd18;
      6'b110010:            x5 = 5'd19;
      6'b001011:            x5 = 5'd20;
      6'b101010:            x5 = 5'd21;
      6'b011010:            x5 = 5'd22;
      6'b111010, 6'b000101: x5 = 5'd23;
      6'b110011, 6'b001100: x5 = 5'd24;
      6'b100110:            x5 = 5'd25;
      6'b010110:            x5 = 5'd26;
      6'b110110, 6'b001001: x5 = 5'd27;
      6'b001110:            x5 = 5'd28;
      6'b101110, 6'b010001: x5 = 5'd29;
      6'b011110, 6'b100001: x5 = 5'd30;
      6'b101011, 6'b010100: x5 = 5'd31;
      6'b001111, 6'b110000: begin x5 = 5'd28; k28 = 1'b1; end
      default:              v6 = 1'b0;
    endcase

    y3 = '0;
    v4 = 1'b1;
    a7 = 1'b0;
    // K28 uses its own 3b/4b column: after 110000 the fghj is the complement
    // of the form that follows 001111, so fold both onto one table.
    four_k = (code[9:4] == 6'b110000) ? ~code[3:0] : code[3:0];
    if (k28) begin
      case (four_k)
        4'b0100: y3 = 3'd0;
        4'b1001: y3 = 3'd1;
        4'b0101: y3 = 3'd2;
        4'b0011: y3 = 3'd3;
        4'b0010: y3 = 3'd4;
        4'b1010: y3 = 3'd5;
        4'b0110: y3 = 3'd6;
        4'b1000: y3 = 3'd7;
        default: v4 = 1'b0;
      endcase
    end else begin
      case (code[3:0])
        4'b1011, 4'b0100: y3 = 3'd0;
        4'b1001:          y3 = 3'd1;
        4'b0101:          y3 = 3'd2;
        4'b1100, 4'b0011: y3 = 3'd3;
        4'b1101, 4'b0010: y3 = 3'd4;
        4'b1010:          y3 = 3'd5;
        4'b0110:          y3 = 3'd6;
        4'b1110, 4'b0001: y3 = 3'd7;
        4'b0111, 4'b1000: begin y3 = 3'd7; a7 = 1'b1; end
        default:          v4 = 1'b0;
      endcase
    end

    data    = {y3, x5};
    invalid = ~(v6 & v4);
    // Kx.7 controls share the alternate .7 form with some data codes; only
    // the byte values in the K list are control symbols.
    k       = ~invalid & (k28 | a7) & is_k_byte({y3, x5});
  end

endmodule

// File: rtl/recibidor_pcie.sv
// Serial 8b/10b lane receiver: comma alignment, symbol decode, 8/16/32-bit word assembly.
// Latency: outputs update on the edge that samples bit j of a symbol (0 extra cycles).
// Backpressure: none; enb low freezes all state and ignores serialIn.
//   Ports: clk, rst (sync, active-high), enb, serialIn (bit a first), dataS[1:0] width select;
//   dataOut8/16/32 assembled words (non-selected held 0), k_out = last symbol was a K code.
module recibidor_pcie
  import pcie_8b10b_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        serialIn,
  input  logic [1:0]  dataS,
  output logic [7:0]  dataOut8,
  output logic [15:0] dataOut16,
  output logic [31:0] dataOut32,
  output logic        k_out
);

  logic [9:0]  sr_q, sr_d;
  logic        aligned_q, aligned_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] stage_q, stage_d;
  logic [7:0]  d8_q, d8_d;
  logic [15:0] d16_q, d16_d;
  logic [31:0] d32_q, d32_d;
  logic        k_q, k_d;
  logic [1:0]  datas_q, datas_d;

  logic [9:0]  nxt;
  logic        comma;
  logic [7:0]  dec_raw;
  logic        dec_raw_k;
  logic        dec_invalid;
  logic [7:0]  dec_byte;
  logic        dec_k;
  logic [1:0]  mode;
  logic [1:0]  bc;
  logic        do_dec;

  // The window including the bit on the wire is what gets matched and decoded,
  // so a symbol is available on the same edge as its last bit.
  assign nxt   = {sr_q[8:0], serialIn};
  assign comma = (nxt == K28_5_RDN) || (nxt == K28_5_RDP);

  decod_8b10b u_dec (
    .code    (nxt),
    .data    (dec_raw),
    .k       (dec_raw_k),
    .invalid (dec_invalid)
  );

  assign dec_byte = dec_invalid ? 8'h00 : dec_raw;
  assign dec_k    = ~dec_invalid & dec_raw_k;
  assign mode     = ((dataS == DATAS_16) || (dataS == DATAS_32)) ? dataS : DATAS_8;

  always_comb begin
    sr_d      = sr_q;
    aligned_d = aligned_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    stage_d   = stage_q;
    d8_d      = d8_q;
    d16_d     = d16_q;
    d32_d     = d32_q;
    k_d       = k_q;
    datas_d   = datas_q;
    bc        = bcnt_q;
    do_dec    = 1'b0;

    if (enb) begin
      sr_d    = nxt;
      datas_d = dataS;

      // Width change: drop any partial word and clear all outputs; a byte
      // decoded on this same edge starts a fresh word.
      if (dataS != datas_q) begin
        bc     = '0;
        bcnt_d = '0;
        d8_d   = '0;
        d16_d  = '0;
        d32_d  = '0;
      end

      if (comma) begin
        // Realign at any bit position; the comma is always byte 0 of a word.
        aligned_d = 1'b1;
        cnt_d     = '0;
        bc        = '0;
        bcnt_d    = '0;
        do_dec    = 1'b1;
      end else if (aligned_q) begin
        if (cnt_q == 4'd9) begin
          cnt_d  = '0;
          do_dec = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      if (do_dec) begin
        k_d = dec_k;
        case (mode)
          DATAS_16: begin
            if (bc == 2'd0) begin
              stage_d[7:0] = dec_byte;
              bcnt_d       = 2'd1;
            end else begin
              d16_d  = {dec_byte, stage_q[7:0]};
              bcnt_d = 2'd0;
            end
          end
          DATAS_32: begin
            case (bc)
              2'd0:    stage_d[7:0]   = dec_byte;
              2'd1:    stage_d[15:8]  = dec_byte;
              2'd2:    stage_d[23:16] = dec_byte;
              default: d32_d          = {dec_byte, stage_q[23:0]};
            endcase
            bcnt_d = bc + 2'd1;
          end
          default: begin
            d8_d   = dec_byte;
            bcnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      aligned_q <= 1'b0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      stage_q   <= '0;
      d8_q      <= '0;
      d16_q     <= '0;
      d32_q     <= '0;
      k_q       <= 1'b0;
      datas_q   <= DATAS_8;
    end else begin
      sr_q      <= sr_d;
      aligned_q <= aligned_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      stage_q   <= stage_d;
      d8_q      <= d8_d;
      d16_q     <= d16_d;
      d32_q     <= d32_d;
      k_q       <= k_d;
      datas_q   <= datas_d;
    end
  end

  assign dataOut8  = d8_q;
  assign dataOut16 = d16_q;
  assign dataOut32 = d32_q;
  assign k_out     = k_q;

endmodule

// File: tb/tb_recibidor_pcie.sv
// Self-checking bench for recibidor_pcie: scoreboard of expected outputs per symbol.
// Latency: expects output update on the edge sampling the 10th enabled bit.
// Backpressure: exercises enb stalls mid-symbol and right before the last bit.
module tb_recibidor_pcie;

  logic        clk;
  logic        rst;
  logic        enb;
  logic        serialIn;
  logic [1:0]  dataS;
  logic [7:0]  dataOut8;
  logic [15:0] dataOut16;
  logic [31:0] dataOut32;
  logic        k_out;

  recibidor_pcie dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .serialIn  (serialIn),
    .dataS     (dataS),
    .dataOut8  (dataOut8),
    .dataOut16 (dataOut16),
    .dataOut32 (dataOut32),
    .k_out     (k_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
    logic        k;
  } exp_t;

  localparam logic [9:0] C_K28_5 = 10'b0011111010;
  localparam logic [9:0] C_D21_5 = 10'b1010101010;
  localparam logic [9:0] C_D10_2 = 10'b0101010101;
  localparam logic [9:0] C_D0_0  = 10'b1001110100;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks;
  int   failures;

  function automatic exp_t observe();
    exp_t o;
    o = {dataOut8, dataOut16, dataOut32, k_out};
    return o;
  endfunction

  task automatic push_exp(input logic [7:0] d8, input logic [15:0] d16,
                          input logic [31:0] d32, input logic k);
    exp_t e;
    e.d8 = d8; e.d16 = d16; e.d32 = d32; e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic b, input logic en);
    serialIn = b;
    enb      = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    last_exp = '0;
  endtask

  // Sends one code-group MSB (bit a) first. Before the last bit the outputs
  // must still hold the previous result; after it they must match the
  // scoreboard head. Optional stall of stall_len cycles after bit stall_after.
  task automatic send_sym(input logic [9:0] code, input string name,
                          input int stall_after, input int stall_len);
    exp_t o;
    exp_t e;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) begin
        o = observe();
        checks++;
        if (o !== last_exp) begin
          failures++;
          $display("FAIL %s_hold: got d8=%h d16=%h d32=%h k=%b want d8=%h d16=%h d32=%h k=%b",
                   name, o.d8, o.d16, o.d32, o.k, last_exp.d8, last_exp.d16, last_exp.d32, last_exp.k);
        end
      end
      step(code[10-n], 1'b1);
      if (n == stall_after) begin
        for (int s = 0; s < stall_len; s++) step(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    o = observe();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got d8=%h d16=%h d32=%h k=%b", name, o.d8, o.d16, o.d32, o.k);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got d8=%h d16=%h d32=%h k=%b want d8=%h d16=%h d32=%h k=%b",
                 name, o.d8, o.d16, o.d32, o.k, e.d8, e.d16, e.d32, e.k);
      end
      last_exp = e;
    end
  endtask

  task automatic test_reset();
    exp_t o;
    dataS = 2'b00;
    do_reset();
    o = observe();
    checks++;
    if (o !== exp_t'(0)) begin
      failures++;
      $display("FAIL reset: got d8=%h d16=%h d32=%h k=%b want all 0", o.d8, o.d16, o.d32, o.k);
    end
  endtask

  // Random bits with no run of five equal bits can never contain a comma.
  task automatic test_no_comma();
    logic [3:0] h;
    logic       b;
    exp_t       o;
    int         bad;
    do_reset();
    dataS = 2'b00;
    h   = 4'b0000;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      b = 1'($urandom_range(0, 1));
      if (h == {4{b}}) b = ~b;
      h = {h[2:0], b};
      step(b, 1'b1);
      o = observe();
      if (o !== exp_t'(0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_comma: %0d cycles with nonzero outputs, want 0", bad);
    end
  endtask

  task automatic test_mode8();
    do_reset();
    dataS = 2'b00;
    push_exp(8'hBC, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "m8_comma", 0, 0);
    push_exp(8'hB5, 16'h0, 32'h0, 1'b0);
    send_sym(C_D21_5, "m8_d21_5", 0, 0);
  endtask

  task automatic test_mode16();
    do_reset();
    dataS = 2'b01;
    push_exp(8'h0, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "m16_comma", 0, 0);
    push_exp(8'h0, 16'h4ABC, 32'h0, 1'b0);
    send_sym(C_D10_2, "m16_d10_2", 0, 0);
  endtask

  task automatic test_mode32();
    do_reset();
    dataS = 2'b10;
    push_exp(8'h0, 16'h0, 32'h0, 1'b1);
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    push_exp(8'h0, 16'h0, 32'h004AB5BC, 1'b0);
    send_sym(C_K28_5, "m32_comma", 0, 0);
    send_sym(C_D21_5, "m32_d21_5", 0, 0);
    send_sym(C_D10_2, "m32_d10_2", 0, 0);
    send_sym(C_D0_0,  "m32_d0_0", 0, 0);
  endtask

  // Runs straight after test_mode32, still aligned on a symbol boundary.
  task automatic test_datas_change();
    exp_t o;
    exp_t e;
    logic [9:0] code;
    code  = C_D21_5;
    dataS = 2'b11;
    push_exp(8'hB5, 16'h0, 32'h0, 1'b0);
    step(code[9], 1'b1);
    o = observe();
    checks++;
    if (o !== exp_t'(0)) begin
      failures++;
      $display("FAIL chg_clear: got d8=%h d16=%h d32=%h k=%b want all 0", o.d8, o.d16, o.d32, o.k);
    end
    for (int i = 8; i >= 0; i--) step(code[i], 1'b1);
    o = observe();
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL chg_mode11: got d8=%h d16=%h d32=%h k=%b want d8=%h d16=%h d32=%h k=%b",
               o.d8, o.d16, o.d32, o.k, e.d8, e.d16, e.d32, e.k);
    end
  endtask

  task automatic test_enb_stall();
    do_reset();
    dataS = 2'b00;
    push_exp(8'hBC, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "stall_comma", 4, 7);
    push_exp(8'hB5, 16'h0, 32'h0, 1'b0);
    send_sym(C_D21_5, "stall_d21_5", 9, 7);
    push_exp(8'h4A, 16'h0, 32'h0, 1'b0);
    send_sym(C_D10_2, "stall_d10_2", 2, 7);
  endtask

  task automatic test_reset_mid();
    exp_t o;
    logic [9:0] code;
    do_reset();
    dataS = 2'b00;
    push_exp(8'hBC, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "rmid_comma", 0, 0);
    code = C_D21_5;
    for (int i = 9; i >= 5; i--) step(code[i], 1'b1);
    do_reset();
    o = observe();
    checks++;
    if (o !== exp_t'(0)) begin
      failures++;
      $display("FAIL rmid_clear: got d8=%h d16=%h d32=%h k=%b want all 0", o.d8, o.d16, o.d32, o.k);
    end
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    send_sym(C_D21_5, "rmid_unaligned", 0, 0);
    push_exp(8'hBC, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "rmid_realign", 0, 0);
  endtask

  task automatic test_midsymbol_comma();
    do_reset();
    dataS = 2'b10;
    push_exp(8'h0, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "mid_comma0", 0, 0);
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    send_sym(C_D21_5, "mid_d21_5a", 0, 0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    push_exp(8'h0, 16'h0, 32'h0, 1'b1);
    send_sym(C_K28_5, "mid_comma1", 0, 0);
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    send_sym(C_D21_5, "mid_d21_5b", 0, 0);
    push_exp(8'h0, 16'h0, 32'h0, 1'b0);
    send_sym(C_D10_2, "mid_d10_2", 0, 0);
    push_exp(8'h0, 16'h0, 32'h004AB5BC, 1'b0);
    send_sym(C_D0_0, "mid_d0_0", 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    enb      = 1'b0;
    serialIn = 1'b0;
    dataS    = 2'b00;
    last_exp = '0;

    test_reset();
    test_no_comma();
    test_mode8();
    test_mode16();
    test_mode32();
    test_datas_change();
    test_enb_stall();
    test_reset_mid();
    test_midsymbol_comma();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
